// File: rtl/lcd_cmd_ctrl.sv
// HD44780 command sequencer: turns a START edge in the LCD register into a timed
// RS/RW/EN/DATA cycle, waits out the controller execution time and reports completion.
module lcd_cmd_ctrl #(
    parameter int SETUP_CYC     = 2,
    parameter int EN_CYC        = 12,
    parameter int HOLD_CYC      = 1,
    parameter int EXEC_CYC      = 2000,
    parameter int LONG_EXEC_CYC = 82000,
    parameter int CNT_W         = 17
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_ctrl,
    input  logic [7:0]  i_lcd_data,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_data_oe,
    output logic [7:0]  o_rd_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ENABLE,
        S_HOLD,
        S_EXEC
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_EXEC_CYC - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_last;
    logic             start_prev;
    logic             start_edge;
    logic             cmd_rs;
    logic             cmd_rw;
    logic [7:0]       cmd_data;
    logic             pend_valid;
    logic             pend_valid_d;
    logic             pend_rs;
    logic             pend_rw;
    logic [7:0]       pend_data;
    logic             is_long;
    logic             at_last;
    logic             complete;
    logic             launch;
    logic             take;
    logic             lcd_on_q;
    logic             busy_q;
    logic             overrun_q;
    logic [7:0]       rd_data_q;
    logic             unused_ctrl_bits;

    assign unused_ctrl_bits = ^i_lcd_ctrl[30:11];

    assign start_edge = i_lcd_ctrl[10] & ~start_prev;
    assign is_long    = ~cmd_rs & ~cmd_rw &
                        (cmd_data == 8'h01 || cmd_data == 8'h02 || cmd_data == 8'h03);
    assign at_last    = (cnt == cnt_last);
    assign complete   = at_last & (((state == S_HOLD) & cmd_rw) | (state == S_EXEC));
    assign launch     = pend_valid | start_edge;
    assign take       = ((state == S_IDLE) | complete) & launch;

    // The pending slot frees when it is launched; a coincident edge refills it.
    always_comb begin
        pend_valid_d = pend_valid;
        if (take)
            pend_valid_d = pend_valid & start_edge;
        else if (start_edge && state != S_IDLE && !pend_valid)
            pend_valid_d = 1'b1;
    end

    always_comb begin
        cnt_last = '0;
        case (state)
            S_SETUP:  cnt_last = SETUP_LAST;
            S_ENABLE: cnt_last = EN_LAST;
            S_HOLD:   cnt_last = HOLD_LAST;
            S_EXEC:   cnt_last = is_long ? LONG_LAST : EXEC_LAST;
            default:  cnt_last = '0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (launch) next_state = S_SETUP;
            S_SETUP:  if (at_last) next_state = S_ENABLE;
            S_ENABLE: if (at_last) next_state = S_HOLD;
            S_HOLD:   if (at_last) next_state = cmd_rw ? (launch ? S_SETUP : S_IDLE) : S_EXEC;
            S_EXEC:   if (at_last) next_state = launch ? S_SETUP : S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            start_prev <= 1'b0;
            lcd_on_q   <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            rd_data_q  <= 8'h00;
            cmd_rs     <= 1'b0;
            cmd_rw     <= 1'b0;
            cmd_data   <= 8'h00;
            pend_valid <= 1'b0;
            pend_rs    <= 1'b0;
            pend_rw    <= 1'b0;
            pend_data  <= 8'h00;
        end else begin
            state      <= next_state;
            start_prev <= i_lcd_ctrl[10];
            lcd_on_q   <= i_lcd_ctrl[31];
            busy_q     <= (next_state != S_IDLE) | pend_valid_d;
            pend_valid <= pend_valid_d;

            if (next_state != state || state == S_IDLE)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);

            if (state == S_ENABLE && at_last && cmd_rw)
                rd_data_q <= i_lcd_data;

            // Launch from the slot first; otherwise the edge goes straight to the bus.
            if (take) begin
                if (pend_valid) begin
                    cmd_rs   <= pend_rs;
                    cmd_rw   <= pend_rw;
                    cmd_data <= pend_data;
                    if (start_edge) begin
                        pend_rs   <= i_lcd_ctrl[9];
                        pend_rw   <= i_lcd_ctrl[8];
                        pend_data <= i_lcd_ctrl[7:0];
                    end
                end else begin
                    cmd_rs   <= i_lcd_ctrl[9];
                    cmd_rw   <= i_lcd_ctrl[8];
                    cmd_data <= i_lcd_ctrl[7:0];
                end
            end else if (start_edge && state != S_IDLE) begin
                if (!pend_valid) begin
                    pend_rs   <= i_lcd_ctrl[9];
                    pend_rw   <= i_lcd_ctrl[8];
                    pend_data <= i_lcd_ctrl[7:0];
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_lcd_on      = lcd_on_q;
        o_lcd_en      = (state == S_ENABLE);
        o_lcd_rs      = cmd_rs;
        o_lcd_rw      = cmd_rw;
        o_lcd_data    = cmd_data;
        o_lcd_data_oe = (state != S_IDLE) & ~cmd_rw;
        o_rd_data     = rd_data_q;
        o_busy        = busy_q;
        o_done        = complete;
        o_overrun     = overrun_q;
    end

endmodule

// File: tb/tb_lcd_cmd_ctrl.sv
// Directed bench for lcd_cmd_ctrl with shortened timing: a table of single commands
// followed by hand-written pending/overrun, held-START and mid-command reset sequences.
module tb_lcd_cmd_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_lcd_ctrl;
    logic [7:0]  i_lcd_data;
    logic        o_lcd_on;
    logic        o_lcd_en;
    logic        o_lcd_rs;
    logic        o_lcd_rw;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_data_oe;
    logic [7:0]  o_rd_data;
    logic        o_busy;
    logic        o_done;
    logic        o_overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ctrl;
        logic [7:0]  lcd_data;
        logic        exp_rs;
        logic        exp_rw;
        logic [7:0]  exp_data;
        logic        exp_oe;
        int          exp_done;
        logic [7:0]  exp_rd;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    lcd_cmd_ctrl #(
        .SETUP_CYC(2), .EN_CYC(4), .HOLD_CYC(1),
        .EXEC_CYC(10), .LONG_EXEC_CYC(50), .CNT_W(17)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_lcd_ctrl(i_lcd_ctrl), .i_lcd_data(i_lcd_data),
        .o_lcd_on(o_lcd_on), .o_lcd_en(o_lcd_en), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
        .o_lcd_data(o_lcd_data), .o_lcd_data_oe(o_lcd_data_oe), .o_rd_data(o_rd_data),
        .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] ctrl, input logic [7:0] data, input logic rst);
        i_lcd_ctrl = ctrl;
        i_lcd_data = data;
        i_reset    = rst;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_on"}, o_lcd_on, 0);
        checkOutput({tag, "_en"}, o_lcd_en, 0);
        checkOutput({tag, "_rs"}, o_lcd_rs, 0);
        checkOutput({tag, "_rw"}, o_lcd_rw, 0);
        checkOutput({tag, "_data"}, o_lcd_data, 0);
        checkOutput({tag, "_oe"}, o_lcd_data_oe, 0);
        checkOutput({tag, "_rd"}, o_rd_data, 0);
        checkOutput({tag, "_busy"}, o_busy, 0);
        checkOutput({tag, "_done"}, o_done, 0);
        checkOutput({tag, "_overrun"}, o_overrun, 0);
    endtask

    initial begin
        int done_cnt;

        //             ctrl          lcd   rs    rw    data   oe   done  rd
        vecs[0] = '{32'h8000_0641, 8'h00, 1'b1, 1'b0, 8'h41, 1'b1, 17, 8'h00};
        vecs[1] = '{32'h8000_0401, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 57, 8'h00};
        vecs[2] = '{32'h8000_0500, 8'h80, 1'b0, 1'b1, 8'h00, 1'b0,  7, 8'h80};
        vecs[3] = '{32'h8000_0403, 8'h00, 1'b0, 1'b0, 8'h03, 1'b1, 57, 8'h80};
        vecs[4] = '{32'h8000_0404, 8'h00, 1'b0, 1'b0, 8'h04, 1'b1, 17, 8'h80};
        vecs[5] = '{32'h8000_0700, 8'h3C, 1'b1, 1'b1, 8'h00, 1'b0,  7, 8'h3C};
        vecs[6] = '{32'h8000_0400, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 17, 8'h3C};
        vecs[7] = '{32'h8000_0601, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1, 17, 8'h3C};

        applyStimulus(32'h8000_0000, 8'h00, 1'b1);
        tick();
        tick();
        checkAllZero("reset");
        applyStimulus(32'h8000_0000, 8'h00, 1'b0);
        tick();
        checkOutput("lcd_on", o_lcd_on, 1);

        for (int v = 0; v < NV; v++) begin
            applyStimulus(vecs[v].ctrl, vecs[v].lcd_data, 1'b0);
            checkOutput("idle_busy", o_busy, 0);
            tick();
            applyStimulus(vecs[v].ctrl & ~32'h0000_0400, vecs[v].lcd_data, 1'b0);
            for (int k = 1; k <= vecs[v].exp_done + 1; k++) begin
                checkOutput("vec_en", o_lcd_en, (k >= 3 && k <= 6));
                checkOutput("vec_done", o_done, (k == vecs[v].exp_done));
                checkOutput("vec_busy", o_busy, (k <= vecs[v].exp_done));
                checkOutput("vec_oe", o_lcd_data_oe, (vecs[v].exp_oe && k <= vecs[v].exp_done));
                if (k == 1) begin
                    checkOutput("vec_rs", o_lcd_rs, vecs[v].exp_rs);
                    checkOutput("vec_rw", o_lcd_rw, vecs[v].exp_rw);
                    checkOutput("vec_data", o_lcd_data, vecs[v].exp_data);
                end
                if (k == vecs[v].exp_done + 1)
                    checkOutput("vec_rd_data", o_rd_data, vecs[v].exp_rd);
                tick();
            end
        end

        // Three edges: second waits in the slot, third is dropped.
        for (int c = 0; c <= 40; c++) begin
            case (c)
                0: applyStimulus(32'h8000_0641, 8'h00, 1'b0);
                1: applyStimulus(32'h8000_0241, 8'h00, 1'b0);
                3: applyStimulus(32'h8000_0442, 8'h00, 1'b0);
                4: applyStimulus(32'h8000_0042, 8'h00, 1'b0);
                6: applyStimulus(32'h8000_0643, 8'h00, 1'b0);
                7: applyStimulus(32'h8000_0243, 8'h00, 1'b0);
                default: ;
            endcase
            checkOutput("pend_done", o_done, (c == 17 || c == 34));
            checkOutput("pend_busy", o_busy, (c >= 1 && c <= 34));
            checkOutput("pend_en", o_lcd_en, ((c >= 3 && c <= 6) || (c >= 20 && c <= 23)));
            checkOutput("pend_overrun", o_overrun, (c >= 7));
            if (c == 18 || c == 35) begin
                checkOutput("pend_rs", o_lcd_rs, 0);
                checkOutput("pend_data", o_lcd_data, 8'h42);
            end
            tick();
        end

        // START held high yields one command; a low-high toggle yields another.
        done_cnt = 0;
        for (int c = 0; c <= 112; c++) begin
            case (c)
                0:   applyStimulus(32'h8000_0500, 8'h55, 1'b0);
                100: applyStimulus(32'h8000_0100, 8'h55, 1'b0);
                101: applyStimulus(32'h8000_0500, 8'h55, 1'b0);
                102: applyStimulus(32'h8000_0100, 8'h55, 1'b0);
                default: ;
            endcase
            if (o_done) done_cnt++;
            if (c == 99)
                checkOutput("held_done_count", done_cnt, 1);
            checkOutput("held_done", o_done, (c == 7 || c == 108));
            if (c == 110)
                checkOutput("held_rd_data", o_rd_data, 8'h55);
            tick();
        end

        // Reset while EN is high aborts the command without a done pulse.
        for (int c = 0; c <= 45; c++) begin
            case (c)
                0:  applyStimulus(32'h8000_0641, 8'h00, 1'b0);
                1:  applyStimulus(32'h8000_0241, 8'h00, 1'b0);
                4:  applyStimulus(32'h8000_0241, 8'h00, 1'b1);
                5:  applyStimulus(32'h8000_0241, 8'h00, 1'b0);
                26: applyStimulus(32'h8000_0641, 8'h00, 1'b0);
                27: applyStimulus(32'h8000_0241, 8'h00, 1'b0);
                default: ;
            endcase
            if (c == 4) begin
                checkOutput("rst_en_before", o_lcd_en, 1);
                checkOutput("rst_overrun_before", o_overrun, 1);
            end
            if (c == 5)
                checkAllZero("rst_abort");
            if (c == 6)
                checkOutput("rst_lcd_on", o_lcd_on, 1);
            checkOutput("rst_done", o_done, (c == 43));
            if (c >= 5)
                checkOutput("rst_busy", o_busy, (c >= 27 && c <= 43));
            if (c >= 29 && c <= 32)
                checkOutput("rst_en_after", o_lcd_en, 1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
